// File: rtl/uart_rx_drain_if.sv
// Handshake bundle between the RX FIFO, the drain block and the downstream consumer.
// master = drain side, slave = FIFO/consumer side.
interface uart_rx_drain_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_rd_en;
  logic [DATA_WIDTH-1:0] rx_rd_data;
  logic                  rx_empty;
  logic [3:0]            rx_level;
  logic                  rx_active;
  logic                  frame_error;
  logic                  overrun_error;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_err;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output rx_rd_en, out_data, out_err, out_valid,
    input  rx_rd_data, rx_empty, rx_level, rx_active, frame_error, overrun_error, out_ready
  );

  modport slave (
    input  rx_rd_en, out_data, out_err, out_valid,
    output rx_rd_data, rx_empty, rx_level, rx_active, frame_error, overrun_error, out_ready
  );
endinterface

// File: rtl/uart_rx_drain.sv
// Drains the RX FIFO into a one-entry valid/ready register and raises the RX interrupt.
// Optional macro RX_DRAIN_ERR_TAG_EN captures {overrun, frame} into out_err with each character.
module uart_rx_drain #(
  parameter int DATA_WIDTH    = 8,
  parameter int TIMEOUT_CHARS = 4
) (
  input  logic                  uart_clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic [3:0]            trig_level,
  input  logic                  timeout_en,
  output logic                  irq,
  output logic                  timeout_flag,
  uart_rx_drain_if.master       bus
);

  localparam int TO_MAX = TIMEOUT_CHARS * 160;
  localparam int CW     = $clog2(TO_MAX + 1);
  localparam logic [CW-1:0] TO_MAX_C = CW'(TO_MAX);

  typedef enum logic [1:0] {IDLE, POP, CAPT, HOLD} state_t;

  state_t                state_q;
  logic                  rd_en_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_valid_q;
  logic [CW-1:0]         to_cnt_q, to_cnt_d;
  logic                  to_flag_q, to_flag_d;
  logic                  irq_q, irq_d;

`ifdef RX_DRAIN_ERR_TAG_EN
  logic [1:0] out_err_q;
`endif

  // rd_en is registered, so it is high exactly during POP; the pop data lands in CAPT.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
`ifdef RX_DRAIN_ERR_TAG_EN
      out_err_q   <= 2'b00;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.rx_empty) begin
            state_q <= POP;
            rd_en_q <= 1'b1;
          end
        end
        POP: begin
          rd_en_q <= 1'b0;
          state_q <= CAPT;
        end
        CAPT: begin
          out_data_q  <= bus.rx_rd_data;
          out_valid_q <= 1'b1;
`ifdef RX_DRAIN_ERR_TAG_EN
          out_err_q   <= {bus.overrun_error, bus.frame_error};
`endif
          state_q     <= HOLD;
        end
        HOLD: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (!bus.rx_empty) begin
              state_q <= POP;
              rd_en_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
    if (rd_en_q || bus.rx_active || bus.rx_empty || !timeout_en) begin
      to_cnt_d = '0;
    end else if (sample_tick && (to_cnt_q != TO_MAX_C)) begin
      to_cnt_d = to_cnt_q + CW'(1);
    end
    // Clear has priority over a same-cycle set.
    if (rd_en_q || !timeout_en) begin
      to_flag_d = 1'b0;
    end else if (to_cnt_d == TO_MAX_C) begin
      to_flag_d = 1'b1;
    end
    irq_d = ((trig_level != 4'd0) && (bus.rx_level >= trig_level)) || to_flag_q;
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.rx_rd_en  = rd_en_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign irq           = irq_q;
  assign timeout_flag  = to_flag_q;

`ifdef RX_DRAIN_ERR_TAG_EN
  assign bus.out_err = out_err_q;
`else
  logic unused_err;
  assign unused_err  = bus.frame_error ^ bus.overrun_error;
  assign bus.out_err = 2'b00;
`endif

endmodule

// File: tb/tb_uart_rx_drain.sv
// Directed bench for uart_rx_drain with a small behavioural RX FIFO driving the pop port.
module tb_uart_rx_drain;

  logic       uart_clk = 1'b0;
  logic       rst;
  logic       sample_tick;
  logic [3:0] trig_level;
  logic       timeout_en;
  logic       irq;
  logic       timeout_flag;

  uart_rx_drain_if #(.DATA_WIDTH(8)) bus ();

  uart_rx_drain #(.DATA_WIDTH(8), .TIMEOUT_CHARS(4)) dut (
    .uart_clk     (uart_clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .trig_level   (trig_level),
    .timeout_en   (timeout_en),
    .irq          (irq),
    .timeout_flag (timeout_flag),
    .bus          (bus)
  );

  always #5 uart_clk = ~uart_clk;

  int errors = 0;
  int checks = 0;

  // FIFO model: pops on rd_en (data valid the next cycle), pushes on push_req.
  logic [7:0] fmem [16];
  int         fwr = 0, frd = 0, fcnt = 0, nxt;
  logic       push_req = 1'b0;
  logic [7:0] push_data = 8'h00;
  int         rd_cnt = 0;

  initial begin
    bus.rx_empty   = 1'b1;
    bus.rx_level   = 4'd0;
    bus.rx_rd_data = 8'h00;
  end

  always @(posedge uart_clk) begin
    nxt = fcnt;
    if (bus.rx_rd_en) rd_cnt++;
    if (bus.rx_rd_en && nxt > 0) begin
      bus.rx_rd_data <= fmem[frd];
      frd = (frd + 1) % 16;
      nxt--;
    end
    if (push_req) begin
      fmem[fwr] = push_data;
      fwr = (fwr + 1) % 16;
      nxt++;
    end
    fcnt = nxt;
    bus.rx_empty <= (nxt == 0);
    bus.rx_level <= 4'(nxt);
  end

  task automatic step(input int n);
    repeat (n) @(posedge uart_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    push_data = d;
    push_req  = 1'b1;
    step(1);
    push_req  = 1'b0;
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    step(1);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp3 [3];
  int         snap;
  int         got;
  logic [1:0] exp_err;

  initial begin
    exp3 = '{8'h11, 8'h22, 8'h33};
`ifdef RX_DRAIN_ERR_TAG_EN
    exp_err = 2'b01;
`else
    exp_err = 2'b00;
`endif
    rst = 1'b1;
    sample_tick = 1'b0;
    trig_level = 4'd0;
    timeout_en = 1'b0;
    bus.rx_active = 1'b0;
    bus.frame_error = 1'b0;
    bus.overrun_error = 1'b0;
    bus.out_ready = 1'b0;
    step(2);
    chk("rst_rd_en", 32'(bus.rx_rd_en), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_timeout_flag", 32'(timeout_flag), 32'd0);
    rst = 1'b0;
    step(1);

    // single byte: POP, CAPT, then valid
    push(8'hA5);
    step(1);
    chk("t1_rd_en_pop", 32'(bus.rx_rd_en), 32'd1);
    chk("t1_valid_early", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("t1_rd_en_one_cycle", 32'(bus.rx_rd_en), 32'd0);
    chk("t1_valid_capt", 32'(bus.out_valid), 32'd0);
    step(1);
    chk("t1_valid", 32'(bus.out_valid), 32'd1);
    chk("t1_data", 32'(bus.out_data), 32'hA5);
    bus.out_ready = 1'b1;
    step(1);
    chk("t1_accept", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    chk("t1_rd_count", 32'(rd_cnt), 32'd1);
    step(2);

    // three bytes with back-pressure
    snap = rd_cnt;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    step(3);
    for (int c = 0; c < 10; c++) begin
      chk("t2_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("t2_hold_data", 32'(bus.out_data), 32'h11);
      step(1);
    end
    chk("t2_single_pop", 32'(rd_cnt - snap), 32'd1);
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      if (bus.out_valid) begin
        chk("t2_order", 32'(bus.out_data), 32'(exp3[got]));
        got++;
      end
      step(1);
    end
    chk("t2_drained", 32'(got), 32'd3);
    bus.out_ready = 1'b0;
    step(2);

    // fill threshold
    trig_level = 4'd4;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    push(8'h04);
    step(5);
    chk("t3_level3", 32'(bus.rx_level), 32'd3);
    chk("t3_irq_below", 32'(irq), 32'd0);
    push(8'h05);
    chk("t3_irq_lag", 32'(irq), 32'd0);
    step(1);
    chk("t3_irq_at_trig", 32'(irq), 32'd1);
    trig_level = 4'd0;
    push(8'h06);
    push(8'h07);
    push(8'h08);
    push(8'h09);
    step(2);
    chk("t3_level8", 32'(bus.rx_level), 32'd8);
    chk("t3_irq_disabled", 32'(irq), 32'd0);
    bus.out_ready = 1'b1;
    step(40);
    chk("t3_drain_valid", 32'(bus.out_valid), 32'd0);
    chk("t3_drain_empty", 32'(bus.rx_empty), 32'd1);
    bus.out_ready = 1'b0;

    // character timeout: one byte held, one still in the FIFO
    timeout_en = 1'b1;
    push(8'h41);
    push(8'h42);
    step(5);
    repeat (639) tick();
    chk("t4_flag_639", 32'(timeout_flag), 32'd0);
    chk("t4_irq_639", 32'(irq), 32'd0);
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    chk("t4_flag_640", 32'(timeout_flag), 32'd1);
    step(1);
    chk("t4_irq_640", 32'(irq), 32'd1);
    timeout_en = 1'b0;
    step(1);
    chk("t4_flag_clear", 32'(timeout_flag), 32'd0);
    step(1);
    chk("t4_irq_clear", 32'(irq), 32'd0);
    timeout_en = 1'b1;
    repeat (600) tick();
    bus.rx_active = 1'b1;
    step(1);
    bus.rx_active = 1'b0;
    step(1);
    repeat (639) tick();
    chk("t4_restart_639", 32'(timeout_flag), 32'd0);
    tick();
    chk("t4_restart_640", 32'(timeout_flag), 32'd1);
    timeout_en = 1'b0;
    bus.out_ready = 1'b1;
    step(12);
    chk("t4_drain_empty", 32'(bus.rx_empty), 32'd1);
    bus.out_ready = 1'b0;

    // error tag
    bus.frame_error = 1'b1;
    push(8'h5A);
    step(4);
    chk("t5_valid", 32'(bus.out_valid), 32'd1);
    chk("t5_out_err", 32'(bus.out_err), 32'(exp_err));
    bus.frame_error = 1'b0;
    bus.out_ready = 1'b1;
    step(2);
    bus.out_ready = 1'b0;
    step(2);

    // reset while in POP
    push(8'h77);
    step(1);
    chk("t6_in_pop", 32'(bus.rx_rd_en), 32'd1);
    rst = 1'b1;
    step(1);
    snap = rd_cnt;
    chk("t6_rd_en", 32'(bus.rx_rd_en), 32'd0);
    chk("t6_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_out_data", 32'(bus.out_data), 32'd0);
    chk("t6_irq", 32'(irq), 32'd0);
    chk("t6_timeout_flag", 32'(timeout_flag), 32'd0);
    step(1);
    rst = 1'b0;
    step(6);
    chk("t6_no_second_pop", 32'(rd_cnt - snap), 32'd0);
    chk("t6_discarded", 32'(bus.out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
